// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational 32-bit ALU between N_REQ
// valid/ready requesters and returns tagged results through a one-entry register.
module alu_share_arbiter #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*32-1:0]    req_a,
  input  logic [N_REQ*32-1:0]    req_b,
  input  logic [N_REQ*4-1:0]     req_ctr,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_err_q, rsp_err_d;

  logic              can_accept;
  logic              grant_found;
  logic              xfer;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic [31:0]       alu_a, alu_b, alu_res;
  logic [3:0]        alu_ctr;
  logic              alu_err;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return ID_W'(sum);
  endfunction

  // Circular scan from rr_ptr; the grant is combinational so a transfer completes in one cycle.
  always_comb begin
    can_accept  = (state_q == EMPTY) || rsp_ready;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    xfer      = grant_found && can_accept && !rst;
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    alu_a   = req_a[int'(grant_idx)*32 +: 32];
    alu_b   = req_b[int'(grant_idx)*32 +: 32];
    alu_ctr = req_ctr[int'(grant_idx)*4 +: 4];
    alu_res = '0;
    alu_err = 1'b0;
    case (alu_ctr)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << alu_b[4:0];
      ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_res = $signed(alu_a) >>> alu_b[4:0];
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, alu_a < alu_b};
      default:  alu_err = 1'b1;
    endcase
  end

  // A drain without a new transfer keeps the payload registers so the bus stays quiet.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    if (xfer) begin
      state_d    = FULL;
      rsp_data_d = alu_res;
      rsp_id_d   = grant_idx;
      rsp_tag_d  = req_tag[int'(grant_idx)*TAG_W +: TAG_W];
      rsp_err_d  = alu_err;
      rr_ptr_d   = (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a reference model predicts grants
// and pushes expected responses into a scoreboard queue that the DUT output drains.
module tb_alu_share_arbiter;

  localparam int N_REQ = 2;
  localparam int TAG_W = 4;
  localparam int ID_W  = 1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  typedef struct packed {
    logic [31:0]      data;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*32-1:0]    req_a, req_b;
  logic [N_REQ*4-1:0]     req_ctr;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic                   rsp_valid, rsp_ready, rsp_err;
  logic [31:0]            rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic [TAG_W-1:0]       rsp_tag;

  logic [31:0]      a_m [N_REQ];
  logic [31:0]      b_m [N_REQ];
  logic [3:0]       ctr_m [N_REQ];
  logic [TAG_W-1:0] tag_m [N_REQ];
  logic [N_REQ-1:0] valid_m;

  rsp_t             sb[$];
  rsp_t             last_rsp;
  int               exp_rr;
  logic [N_REQ-1:0] last_ready;
  logic             keep_valid;
  logic [31:0]      held;
  int               errors = 0;
  int               checks = 0;

  assign req_valid = valid_m;
  assign req_a     = {a_m[1], a_m[0]};
  assign req_b     = {b_m[1], b_m[0]};
  assign req_ctr   = {ctr_m[1], ctr_m[0]};
  assign req_tag   = {tag_m[1], tag_m[0]};

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctr(req_ctr), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [32:0] refAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a << b[4:0]};
      4'd3: return {1'b0, a >> b[4:0]};
      4'd4: return {1'b0, 32'($signed(a) >>> b[4:0])};
      4'd5: return {1'b0, a & b};
      4'd6: return {1'b0, a | b};
      4'd7: return {1'b0, a ^ b};
      4'd8: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      4'd9: return {1'b0, 31'd0, (a < b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic applyStimulus(input int i, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [TAG_W-1:0] t);
    ctr_m[i]   = c;
    a_m[i]     = a;
    b_m[i]     = b;
    tag_m[i]   = t;
    valid_m[i] = 1'b1;
  endtask

  task automatic refill(input int i);
    applyStimulus(i, 4'($urandom_range(0, 15)), $urandom, $urandom, TAG_W'($urandom));
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic step();
    logic [N_REQ-1:0] exp_ready;
    logic             acc;
    logic [32:0]      r;
    rsp_t             e;
    int               g;
    int               idx;
    @(negedge clk);
    acc = (sb.size() == 0) || rsp_ready;
    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (exp_rr + k) % N_REQ;
      if (g < 0 && valid_m[idx]) g = idx;
    end
    exp_ready = '0;
    if (!rst && acc && g >= 0) exp_ready[g] = 1'b1;
    e = (sb.size() != 0) ? sb[0] : last_rsp;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
    checkOutput("rsp_data",  64'(rsp_data),  64'(e.data));
    checkOutput("rsp_id",    64'(rsp_id),    64'(e.id));
    checkOutput("rsp_tag",   64'(rsp_tag),   64'(e.tag));
    checkOutput("rsp_err",   64'(rsp_err),   64'(e.err));
    last_ready = req_ready;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      last_rsp = '0;
      exp_rr   = 0;
    end else begin
      if (sb.size() != 0 && rsp_ready) last_rsp = sb.pop_front();
      if (exp_ready != '0) begin
        r = refAlu(ctr_m[g], a_m[g], b_m[g]);
        sb.push_back('{data: r[31:0], id: ID_W'(g), tag: tag_m[g], err: r[32]});
        exp_rr = (g + 1) % N_REQ;
      end
    end
    #1;
    if (exp_ready != '0) begin
      if (keep_valid) refill(g);
      else valid_m[g] = 1'b0;
    end
  endtask

  task automatic runOne(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input logic [31:0] exp_data, input logic exp_err,
                        input string name);
    applyStimulus(i, c, a, b, t);
    step();
    checkOutput({name, "_data"}, 64'(rsp_data), 64'(exp_data));
    checkOutput({name, "_err"},  64'(rsp_err),  64'(exp_err));
    step();
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    valid_m = '0;
    keep_valid = 1'b0;
    exp_rr = 0;
    last_rsp = '0;
    last_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      a_m[i] = '0; b_m[i] = '0; ctr_m[i] = '0; tag_m[i] = '0;
    end
    @(posedge clk);
    #1;

    $display("[TB] reset with both requesters valid");
    refill(0);
    refill(1);
    step();
    step();
    rst = 1'b0;
    step();
    checkOutput("first_grant", 64'(last_ready), 64'(2'b01));
    step();
    step();

    $display("[TB] single add and arithmetic corners");
    runOne(0, ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, "add");
    runOne(0, ALU_SRA, 32'h8000_0000, 32'h24, 4'd1, 32'hF800_0000, 1'b0, "sra");
    runOne(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1, 1'b0, "slt");
    runOne(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 1'b0, "sltu");
    runOne(1, ALU_SUB, 32'd0, 32'd1, 4'd5, 32'hFFFF_FFFF, 1'b0, "sub");
    runOne(0, ALU_MUL, 32'd6, 32'd7, 4'd6, 32'd0, 1'b1, "mul");
    runOne(1, ALU_ADD, 32'd1, 32'd1, 4'd7, 32'd2, 1'b0, "add1");

    $display("[TB] contention");
    keep_valid = 1'b1;
    refill(0);
    refill(1);
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput("cont_grant", 64'(last_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
    end

    $display("[TB] back-pressure");
    rsp_ready = 1'b0;
    held = rsp_data;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("bp_ready", 64'(last_ready), 64'h0);
      checkOutput("bp_hold",  64'(rsp_data), 64'(held));
    end
    rsp_ready = 1'b1;
    step();
    checkOutput("bp_accept", 64'(last_ready != '0), 64'h1);
    keep_valid = 1'b0;
    valid_m = '0;
    step();
    step();

    $display("[TB] reset while full");
    applyStimulus(1, ALU_ADD, 32'd9, 32'd9, 4'd9);
    step();
    rsp_ready = 1'b0;
    refill(0);
    refill(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_full_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_full_data",  64'(rsp_data),  64'h0);
    rsp_ready = 1'b1;
    step();
    checkOutput("rst_first_grant", 64'(last_ready), 64'h1);
    step();
    step();

    $display("[TB] lone requester 1");
    keep_valid = 1'b1;
    refill(1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("lone_grant", 64'(last_ready), 64'h2);
    end
    valid_m = '0;
    keep_valid = 1'b0;
    step();

    $display("[TB] random traffic");
    keep_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < N_REQ; i++)
        if (!valid_m[i] && $urandom_range(0, 1) == 1) refill(i);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    keep_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational 32-bit `ALU_Base` between `N_REQ` requesters, such as the execute stage and an address/CSR helper, using round-robin arbitration. Each requester uses a valid/ready handshake. The selected operation runs through the ALU, and its result is captured in a single-entry output register. That register is returned on one response channel tagged with the requester index and a caller tag. The block sits between the requesters and the ALU and owns all sequencing, back-pressure and unsupported-opcode flagging.

## Interface
- `N_REQ`, default 2: number of requesters (2..8).
- `TAG_W`, default 4: width of the caller tag carried through with each operation.
- `ID_W`, default `$clog2(N_REQ)`: requester-index width (minimum 1).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `N_REQ`: requester i presents an operation.
- `req_ready` out `N_REQ`: grant; at most one bit set per cycle.
- `req_a` in `N_REQ*32`: operand A, packed, requester i at `[32*i +: 32]`.
- `req_b` in `N_REQ*32`: operand B, packed likewise.
- `req_ctr` in `N_REQ*4`: ALU control code from `alu_definitions.svh`.
- `req_tag` in `N_REQ*TAG_W`: caller tag.
- `rsp_valid` out 1: the response register holds a result.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_data` out 32: ALU result.
- `rsp_id` out `ID_W`: index of the requester that produced the result.
- `rsp_tag` out `TAG_W`: tag copied from the request.
- `rsp_err` out 1: set when `req_ctr` is not one of the ten supported codes.

## Operation
- **Supported codes:** `ALU_ADD`, `SUB`, `SLL`, `SRL`, `SRA`, `AND`, `OR`, `XOR`, `SLT`, `SLTU`.
- **Unsupported codes:** any other code, including `ALU_MUL`, yields `rsp_data` = 0 and `rsp_err` = 1.
- **Output FSM**, two states:
  - EMPTY: `rsp_valid` = 0.
  - FULL: `rsp_valid` = 1.
- **Accept condition:** `can_accept` = EMPTY | (FULL & `rsp_ready`).
- **Arbitration:** when `can_accept` holds and any `req_valid` is set, grant the first valid requester found scanning circularly from `rr_ptr`. Assert that requester's `req_ready` bit combinationally in the same cycle.
- **Ready/valid dependency:** `req_ready` depends on `req_valid` and `rsp_ready`; `req_valid` must never depend on `req_ready`.
- **Transfer:** a transfer occurs on `req_valid[i]` & `req_ready[i]`. The granted operands are muxed into the single ALU instance. On that edge the block loads `rsp_data`, `rsp_id` = i, `rsp_tag`, `rsp_err` and `rr_ptr` = (i+1) mod `N_REQ`, then goes to or stays in FULL.
- **Drain:** in FULL with `rsp_ready` and no transfer, go to EMPTY. The data, id, tag and err registers keep their last values.
- **Hold:** in FULL with `!rsp_ready`, all `req_ready` bits are 0 and every response field is held bit-stable.
- **Requester rule:** a requester holds `req_valid` and its payload stable until granted. An ungranted requester with valid set is never dropped, and it is granted within `N_REQ` transfers.
- **Width rules:**
  - Shifts use `B[4:0]` only.
  - `SRA` is arithmetic on signed A.
  - `SLT` compares signed; `SLTU` compares unsigned.
  - Results are 1 or 0, zero-extended to 32 bits.
  - `ADD`/`SUB` wrap modulo 2^32.

## Timing
- **Reset values:** every output is 0, so `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `rsp_tag` = 0, `rsp_err` = 0 and `req_ready` = 0. `rr_ptr` = 0 and the state is EMPTY.
- **During reset:** `req_ready` is forced to 0 for the full duration of `rst`.
- **Latency:** a request granted in cycle n produces `rsp_valid` in cycle n+1.
- **Throughput:** one operation per cycle while `rsp_ready` stays high.
- **Simultaneous drain and accept in FULL:** with `rsp_ready` = 1 and a new transfer in the same cycle, the old response is consumed and the new one is loaded at the same edge. `rsp_valid` stays 1 with no bubble.
- **Reset mid-operation:** `rst` while FULL discards the held result. The next cycle shows EMPTY with all outputs 0 and `rr_ptr` = 0. No partial transfer is reported.
- **Pointer wrap:** `rr_ptr` wraps from `N_REQ`-1 to 0. A lone requester is granted every cycle regardless of `rr_ptr`.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `req_valid` = 2'b11 and `rsp_ready` = 1 -> `req_ready` = 0, all `rsp_*` = 0 throughout and 1 cycle after release. Then requester 0 is granted first.
- **Single add:** req0 sends `ALU_ADD` with A = 5, B = 7, tag = 3 -> `req_ready[0]` asserts the same cycle. Next cycle `rsp_valid` = 1, `rsp_data` = 12, `rsp_id` = 0, `rsp_tag` = 3, `rsp_err` = 0.
- **Contention:** both requesters valid for 6 cycles with `rsp_ready` = 1 -> grants go 0,1,0,1,0,1 and `rsp_valid` stays high continuously from cycle 2.
- **Back-pressure:** drop `rsp_ready` for 3 cycles while FULL -> `req_ready` = 0 and `rsp_*` stable. Raise `rsp_ready` -> the held result drains and the pending request is accepted at the same edge.
- **Arithmetic corners:**
  - `SRA` with A = 32'h8000_0000, B = 32'h24 -> 32'hF800_0000.
  - `SLT` with A = 32'hFFFF_FFFF, B = 1 -> 1; `SLTU` with the same operands -> 0.
  - `SUB` with A = 0, B = 1 -> 32'hFFFF_FFFF.
- **Error and reset:**
  - `ALU_MUL` code -> `rsp_data` = 0, `rsp_err` = 1.
  - Assert `rst` while FULL with `rsp_ready` = 0 -> next cycle `rsp_valid` = 0 and the next grant goes to requester 0.
